// File: rtl/spi_cmd_controller.sv
// Command sequencer behind spi_slave: decodes CMD/LEN/data frames from the SPI RX FIFO into
// register-bank accesses. Define SPI_CMD_TIMEOUT_EN to enable the inter-byte frame timeout.
module spi_cmd_controller #(
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_fifo_data,
    input  logic              rx_fifo_empty,
    output logic              rx_fifo_read_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    typedef enum logic [3:0] {
        StIdle,
        StCmdWait,
        StLenFetch,
        StLenWait,
        StWrFetch,
        StWrWait,
        StRdIssue,
        StRdCapture,
        StRdPush,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              is_write_q, is_write_d;
    logic              auto_inc_q, auto_inc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;

    logic pop;
    logic rd_strobe;
    logic tx_accept;
    logic timeout;

    assign tx_accept = tx_valid_q && tx_ready;

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        auto_inc_d = auto_inc_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        wr_en_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pop        = 1'b0;
        rd_strobe  = 1'b0;

        case (state_q)
            StIdle: begin
                if (!rx_fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StCmdWait;
                end
            end
            StCmdWait: begin
                is_write_d = rx_fifo_data[7];
                auto_inc_d = rx_fifo_data[6];
                addr_d     = rx_fifo_data[ADDR_W-1:0];
                state_d    = StLenFetch;
            end
            StLenFetch: begin
                if (!rx_fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StLenWait;
                end
            end
            StLenWait: begin
                count_d = rx_fifo_data;
                if (rx_fifo_data == 8'd0) begin
                    state_d = StDone;
                end else if (is_write_q) begin
                    state_d = StWrFetch;
                end else begin
                    state_d = StRdIssue;
                end
            end
            StWrFetch: begin
                if (!rx_fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StWrWait;
                end
            end
            StWrWait: begin
                wdata_d = rx_fifo_data;
                wr_en_d = 1'b1;
                count_d = count_q - 8'd1;
                state_d = (count_q == 8'd1) ? StDone : StWrFetch;
            end
            StRdIssue: begin
                rd_strobe = 1'b1;
                state_d   = StRdCapture;
            end
            StRdCapture: begin
                tx_data_d  = reg_rdata;
                tx_valid_d = 1'b1;
                state_d    = StRdPush;
            end
            StRdPush: begin
                if (tx_accept) begin
                    tx_valid_d = 1'b0;
                    count_d    = count_q - 8'd1;
                    state_d    = (count_q == 8'd1) ? StDone : StRdIssue;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Step the address in the cycle the access strobe is on the bus, so the strobe sees
        // the pre-increment address. A write strobe never coincides with StCmdWait.
        if ((wr_en_q || rd_strobe) && auto_inc_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (timeout) begin
            state_d    = StIdle;
            tx_valid_d = 1'b0;
            wr_en_d    = 1'b0;
        end
    end

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TimerW-1:0] timer_q, timer_d;
    logic              waiting;

    assign waiting = ((state_q == StLenFetch || state_q == StWrFetch) && rx_fifo_empty) ||
                     ((state_q == StRdPush) && !tx_ready);

    // Counts clocks since the last pop or tx handshake; it can only expire while stalled.
    always_comb begin
        timer_d = timer_q;
        if (state_q == StIdle || pop || tx_accept) begin
            timer_d = '0;
        end else if (state_q != StDone) begin
            timer_d = timer_q + TimerW'(1);
        end
    end

    assign timeout = waiting && (timer_q >= TimerW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            is_write_q <= 1'b0;
            auto_inc_q <= 1'b0;
            addr_q     <= '0;
            count_q    <= 8'd0;
            wdata_q    <= 8'd0;
            wr_en_q    <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            auto_inc_q <= auto_inc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Strobes and tx_valid are masked by reset so nothing fires in the reset cycle itself.
    assign rx_fifo_read_en = pop && !reset;
    assign reg_rd_en       = rd_strobe && !reset;
    assign reg_wr_en       = wr_en_q && !reset;
    assign tx_valid        = tx_valid_q && !reset;
    assign frame_done      = (state_q == StDone) && !reset;
    assign frame_err       = timeout && !reset;
    assign reg_addr        = addr_q;
    assign reg_wdata       = wdata_q;
    assign tx_data         = tx_data_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Scoreboard bench for spi_cmd_controller: FIFO and register models, expected accesses queued
// at stimulus time and compared when the DUT strobes.
module tb_spi_cmd_controller;
    localparam int unsigned ADDR_W         = 6;
    localparam int unsigned TIMEOUT_CYCLES = 50;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        rx_fifo_data;
    logic              rx_fifo_empty;
    logic              rx_fifo_read_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [7:0]        reg_rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              frame_done;
    logic              frame_err;

    spi_cmd_controller #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .rx_fifo_data    (rx_fifo_data),
        .rx_fifo_empty   (rx_fifo_empty),
        .rx_fifo_read_en (rx_fifo_read_en),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_wr_en       (reg_wr_en),
        .reg_rd_en       (reg_rd_en),
        .reg_rdata       (reg_rdata),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .busy            (busy),
        .frame_done      (frame_done),
        .frame_err       (frame_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0]        fifo_q[$];
    logic [13:0]       exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];
    logic [7:0]        exp_tx[$];

    int         done_cnt = 0;
    int         err_cnt = 0;
    int         err_cyc = 0;
    int         last_pop_cyc = 0;
    int         rd_cyc = 0;
    int         hs_cyc = 0;
    bit         hs_pending = 1'b0;
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic [7:0] rd_val;
    logic [13:0] e_wr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc++;

    // RX FIFO model: popped byte appears on rx_fifo_data shortly after the pop edge.
    always @(posedge clock) begin
        if (rx_fifo_read_en) begin
            #1;
            if (fifo_q.size() > 0) rx_fifo_data = fifo_q.pop_front();
            rx_fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Register model: read data is addr + 0x10, valid the cycle after reg_rd_en.
    always @(posedge clock) begin
        if (reg_rd_en) begin
            rd_val = {2'b00, reg_addr} + 8'h10;
            #1;
            reg_rdata = rd_val;
        end
    end

    // Monitor samples mid-cycle, after the negedge input updates and before the next posedge.
    always @(negedge clock) begin
        #2;
        if (reg_wr_en) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 32'(reg_wr_en), 32'd0);
            end else begin
                e_wr = exp_wr.pop_front();
                check("wr_addr", 32'(reg_addr), 32'(e_wr[13:8]));
                check("wr_data", 32'(reg_wdata), 32'(e_wr[7:0]));
                check("wr_latency", cyc - last_pop_cyc, 32'd2);
            end
        end
        if (rx_fifo_read_en) begin
            check("pop_not_empty", 32'(rx_fifo_empty), 32'd0);
            last_pop_cyc = cyc;
        end
        if (prev_stall) begin
            check("tx_hold_valid", 32'(tx_valid), 32'd1);
            check("tx_hold_data", 32'(tx_data), 32'(prev_data));
            check("no_rd_in_stall", 32'(reg_rd_en), 32'd0);
        end
        if (reg_rd_en) begin
            if (exp_rd.size() == 0) begin
                check("rd_unexpected", 32'(reg_rd_en), 32'd0);
            end else begin
                check("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
            end
            if (hs_pending) check("rd_after_hs", cyc - hs_cyc, 32'd1);
            hs_pending = 1'b0;
            rd_cyc = cyc;
        end
        if (tx_valid && !prev_valid) check("rd_to_valid", cyc - rd_cyc, 32'd2);
        if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
                check("tx_unexpected", 32'(tx_valid), 32'd0);
            end else begin
                check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            hs_cyc = cyc;
            hs_pending = (exp_rd.size() > 0);
        end
        if (frame_done) done_cnt++;
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_valid = tx_valid;
        prev_data  = tx_data;
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge clock);
        fifo_q.push_back(b);
        rx_fifo_empty = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 300 && done_cnt < target; i++) @(negedge clock);
        check(tag, done_cnt, target);
    endtask

    int d;
    int e;

    initial begin
        reset         = 1'b1;
        tx_ready      = 1'b1;
        rx_fifo_data  = 8'd0;
        rx_fifo_empty = 1'b1;
        reg_rdata     = 8'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_wr_en", 32'(reg_wr_en), 32'd0);
        check("rst_rd_en", 32'(reg_rd_en), 32'd0);

        // Write, no auto-increment, address 5.
        d = done_cnt;
        exp_wr.push_back({6'd5, 8'hAA});
        exp_wr.push_back({6'd5, 8'hBB});
        push_byte(8'h85);
        push_byte(8'h02);
        push_byte(8'hAA);
        push_byte(8'hBB);
        wait_done("t1_done", d + 1);
        idle(3);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_wr_left", exp_wr.size(), 32'd0);
        check("t1_done_once", done_cnt, d + 1);

        // Read burst with auto-increment wrapping 0x3F -> 0x00.
        d = done_cnt;
        exp_rd.push_back(6'h3E);
        exp_rd.push_back(6'h3F);
        exp_rd.push_back(6'h00);
        exp_tx.push_back(8'h4E);
        exp_tx.push_back(8'h4F);
        exp_tx.push_back(8'h10);
        push_byte(8'h7E);
        push_byte(8'h03);
        wait_done("t2_done", d + 1);
        idle(3);
        check("t2_rd_left", exp_rd.size(), 32'd0);
        check("t2_tx_left", exp_tx.size(), 32'd0);

        // Backpressure: hold tx_ready low for 20 cycles with the first byte pending.
        d = done_cnt;
        tx_ready = 1'b0;
        exp_rd.push_back(6'h0A);
        exp_rd.push_back(6'h0B);
        exp_tx.push_back(8'h1A);
        exp_tx.push_back(8'h1B);
        push_byte(8'h4A);
        push_byte(8'h02);
        for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clock);
        check("t3_valid_seen", 32'(tx_valid), 32'd1);
        idle(20);
        check("t3_still_valid", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        wait_done("t3_done", d + 1);
        idle(3);
        check("t3_rd_left", exp_rd.size(), 32'd0);
        check("t3_tx_left", exp_tx.size(), 32'd0);

        // LEN=0 with a trickle-fed FIFO: no register access, one frame_done.
        d = done_cnt;
        push_byte(8'h81);
        idle(5);
        push_byte(8'h00);
        wait_done("t4_done", d + 1);
        idle(3);
        check("t4_done_once", done_cnt, d + 1);
        check("t4_busy", 32'(busy), 32'd0);

        // Reset after the LEN byte of a 4-byte write; the partial frame is dropped.
        d = done_cnt;
        push_byte(8'h83);
        push_byte(8'h04);
        for (int i = 0; i < 20 && fifo_q.size() > 0; i++) @(negedge clock);
        idle(2);
        check("t5_busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        #3;
        check("t5_rst_wr", 32'(reg_wr_en), 32'd0);
        check("t5_rst_pop", 32'(rx_fifo_read_en), 32'd0);
        check("t5_rst_done", 32'(frame_done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #3;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_addr", 32'(reg_addr), 32'd0);
        check("t5_wdata", 32'(reg_wdata), 32'd0);
        check("t5_tx_data", 32'(tx_data), 32'd0);
        check("t5_tx_valid", 32'(tx_valid), 32'd0);
        exp_wr.push_back({6'd2, 8'h11});
        exp_wr.push_back({6'd3, 8'h22});
        push_byte(8'hC2);
        push_byte(8'h02);
        push_byte(8'h11);
        push_byte(8'h22);
        wait_done("t5_done", d + 1);
        idle(3);
        check("t5_wr_left", exp_wr.size(), 32'd0);

`ifdef SPI_CMD_TIMEOUT_EN
        // Only the CMD byte arrives: the frame must time out.
        e = err_cnt;
        d = done_cnt;
        push_byte(8'h81);
        for (int i = 0; i < 150 && err_cnt == e; i++) @(negedge clock);
        check("t6_err_seen", err_cnt, e + 1);
        check("t6_err_delay", err_cyc - last_pop_cyc, TIMEOUT_CYCLES);
        idle(2);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_no_done", done_cnt, d);
`else
        check("no_frame_err", err_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_controller.md
Name: spi_cmd_controller

Overview:
Command sequencer behind spi_slave: drains received bytes from the SPI RX FIFO and decodes them into register-bank read/write transactions. Read results are queued toward the MISO-side byte loader via a valid/ready handshake. Sits between spi_slave and the top-level register/peripheral space. It is the only agent issuing read_en on the SPI RX FIFO.

Parameters:
ADDR_W, 6, register address width; auto-increment wraps modulo 2^ADDR_W
TIMEOUT_CYCLES, 2700000, idle clocks tolerated between bytes of one frame (100 ms at 27 MHz)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_fifo_data  in  8  SPI RX FIFO data_out; valid the cycle after rx_fifo_read_en
rx_fifo_empty  in  1  SPI RX FIFO empty flag
rx_fifo_read_en  out  1  one-cycle pop strobe to SPI RX FIFO
reg_addr  out  ADDR_W  register address
reg_wdata  out  8  register write data
reg_wr_en  out  1  one-cycle write strobe
reg_rd_en  out  1  one-cycle read strobe
reg_rdata  in  8  register read data, valid the cycle after reg_rd_en
tx_data  out  8  read byte for MISO loader
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  MISO loader accepts byte when tx_valid&tx_ready
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse at completion of a frame
frame_err  out  1  one-cycle pulse on frame abort (timeout)

Behaviour:
- Frame format: CMD, LEN, then data. CMD[7]=1 write / 0 read; CMD[6]=auto-increment; CMD[ADDR_W-1:0]=start address (bits above ADDR_W, excluding 7:6, ignored). LEN = byte count 0..255.
- Write frame: LEN data bytes follow. Each byte produces one reg_wr_en.
- Read frame: no further RX bytes. Controller performs LEN reads, each result pushed to tx.
- LEN=0: frame completes immediately after the LEN byte, with no register access.
- FIFO pop rule: rx_fifo_read_en only when !rx_fifo_empty and no pop outstanding. Byte is consumed the following cycle.
- States:
  - IDLE: pop when data available -> CMD_WAIT.
  - CMD_WAIT: latch cmd/addr -> LEN_FETCH.
  - LEN_FETCH: pop when available -> LEN_WAIT.
  - LEN_WAIT: latch count; count==0 -> DONE; write -> WR_FETCH; read -> RD_ISSUE.
  - WR_FETCH: pop -> WR_WAIT.
  - WR_WAIT: reg_wdata<=byte, reg_wr_en pulse, count-1; count reaches 0 -> DONE, else -> WR_FETCH.
  - RD_ISSUE: reg_rd_en pulse -> RD_CAPTURE.
  - RD_CAPTURE: tx_data<=reg_rdata, tx_valid<=1 -> RD_PUSH.
  - RD_PUSH: on tx_ready, tx_valid<=0, count-1; count reaches 0 -> DONE, else -> RD_ISSUE.
  - DONE: frame_done pulse -> IDLE.
- Address: after each access, addr+1 if CMD[6], else unchanged. Wraps 2^ADDR_W-1 -> 0.
- Latency:
  - Write byte: register write strobe 2 cycles after the pop, with the FIFO non-empty.
  - Read: reg_rd_en to tx_valid = 2 cycles. Next reg_rd_en is 1 cycle after the tx handshake.
- Backpressure: tx_valid/tx_data stable while tx_ready low. No further reg_rd_en until accepted.
- Reset values: all strobes 0, tx_valid 0, tx_data 0, reg_addr 0, reg_wdata 0, busy 0, state IDLE, timer 0.
- Reset mid-frame: immediate return to IDLE, no strobe that cycle, partial frame discarded. The FIFO is not flushed.
- Simultaneous tx_valid and reset: reset wins, tx_valid 0.
- Counters are 8-bit internal. The frame terminates on the count==0 check, never by underflow.

Optional Feature:
SPI_CMD_TIMEOUT_EN
- Defined:
  - Per-frame timer, cleared on every RX pop and every tx handshake.
  - Increments in CMD_WAIT..RD_PUSH while waiting (FIFO empty in a fetch state, or tx_ready low in RD_PUSH).
  - On reaching TIMEOUT_CYCLES: frame_err pulse, tx_valid<=0, -> IDLE, no register strobe.
- Undefined:
  - No timer logic, frame_err tied 0.
  - Controller waits indefinitely.

Test Plan:
- Write, no auto-inc: FIFO 0x85,0x02,0xAA,0xBB -> reg_wr_en twice at addr 5 with data 0xAA then 0xBB; one frame_done; busy low after.
- Read burst with wrap, ADDR_W=6: FIFO 0x7E,0x03; reg_rdata=addr+0x10 -> reg_rd_en at addr 0x3E,0x3F,0x00; tx bytes 0x4E,0x4F,0x10.
- Backpressure: read frame LEN=2 with tx_ready low 20 cycles -> tx_valid and tx_data held constant; second reg_rd_en 1 cycle after the handshake.
- LEN=0 and trickle-fed FIFO: 0x81,0x00 with gaps of 5 empty cycles -> no register strobes; frame_done once; rx_fifo_read_en never asserted while empty.
- Reset mid-frame: assert reset after the LEN byte of a 4-byte write -> no further reg_wr_en; outputs at reset values next cycle; the next frame decodes correctly.
- SPI_CMD_TIMEOUT_EN with TIMEOUT_CYCLES=50: FIFO 0x81 only -> frame_err pulse 50 cycles after the last pop; state IDLE; no reg_wr_en.
